// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/M memory port arbiter: address/data types, FSM
// states, owner tags and the captured request record.
package mem_port_arbiter_pkg;

    localparam int MemAddrWidth = 16;
    localparam int DataWidth    = 32;

    typedef logic                    Signal;
    typedef logic [DataWidth-1:0]    Register;
    typedef logic [MemAddrWidth-1:0] MemAddr;

    typedef enum logic [1:0] {IDLE, GRANT, WAIT, DONE} ArbState;
    typedef enum logic {OWN_IF, OWN_D} Owner;

    typedef struct packed {
        Signal   we;
        MemAddr  addr;
        Register wdata;
    } MemReq;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter tracking the remaining memory latency of a read.
// Reloads to MEM_LATENCY-1 and stops at zero.
module mem_lat_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_LATENCY = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);

    localparam int            CntW    = cnt_width(MEM_LATENCY - 1);
    localparam logic [CntW-1:0] LoadVal = CntW'(MEM_LATENCY - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LoadVal;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between fetch and data accesses, one
// access at a time, with data priority and a starvation guard for fetch.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req,
    input  logic [MemAddrWidth-1:0] if_addr,
    output logic                    if_gnt,
    output logic                    if_valid,
    output logic [31:0]             if_rdata,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [MemAddrWidth-1:0] d_addr,
    input  logic [31:0]             d_wdata,
    output logic                    d_gnt,
    output logic                    d_valid,
    output logic [31:0]             d_rdata,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [MemAddrWidth-1:0] mem_addr,
    output logic [31:0]             mem_wdata,
    input  logic [31:0]             mem_rdata,
    output logic                    stall_if,
    output logic                    stall_d
);

    localparam int                StarveW   = cnt_width(STARVE_LIMIT);
    localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

    ArbState              state_q, state_d;
    Owner                 owner_q, owner_d;
    MemReq                req_q, req_d;
    logic [StarveW-1:0]   starve_q, starve_d;
    logic                 if_gnt_q, if_gnt_d, d_gnt_q, d_gnt_d;
    logic                 if_valid_q, if_valid_d, d_valid_q, d_valid_d;
    Register              if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
    logic                 mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    MemAddr               mem_addr_q, mem_addr_d;
    Register              mem_wdata_q, mem_wdata_d;
    logic                 lat_load, lat_dec, lat_zero;

    mem_lat_counter #(
        .MEM_LATENCY(MEM_LATENCY)
    ) u_lat_counter (
        .clk    (clk),
        .rst    (rst),
        .load_i (lat_load),
        .dec_i  (lat_dec),
        .zero_o (lat_zero)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        req_d       = req_q;
        starve_d    = starve_q;
        if_gnt_d    = 1'b0;
        d_gnt_d     = 1'b0;
        if_valid_d  = 1'b0;
        d_valid_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        lat_load    = 1'b0;
        lat_dec     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    // Data wins unless fetch has lost STARVE_LIMIT times in a row;
                    // starve_q < StarveMax here, so the increment cannot overflow.
                    if (d_req && (!if_req || (starve_q != StarveMax))) begin
                        owner_d = OWN_D;
                        req_d   = '{we: d_we, addr: d_addr, wdata: d_wdata};
                        if (if_req) begin
                            starve_d = starve_q + 1'b1;
                        end
                    end else begin
                        owner_d  = OWN_IF;
                        req_d    = '{we: 1'b0, addr: if_addr, wdata: '0};
                        starve_d = '0;
                    end
                    state_d     = GRANT;
                    if_gnt_d    = (owner_d == OWN_IF);
                    d_gnt_d     = (owner_d == OWN_D);
                    mem_en_d    = 1'b1;
                    mem_we_d    = req_d.we;
                    mem_addr_d  = req_d.addr;
                    mem_wdata_d = req_d.wdata;
                end
            end
            GRANT: begin
                lat_load = 1'b1;
                if (req_q.we) begin
                    state_d = DONE;
                    if (owner_q == OWN_D) begin
                        d_valid_d = 1'b1;
                        d_rdata_d = '0;
                    end else begin
                        if_valid_d = 1'b1;
                    end
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                lat_dec = 1'b1;
                if (lat_zero) begin
                    state_d = DONE;
                    if (owner_q == OWN_IF) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = mem_rdata;
                    end else begin
                        d_valid_d = 1'b1;
                        d_rdata_d = mem_rdata;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            req_q       <= '0;
            starve_q    <= '0;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            req_q       <= req_d;
            starve_q    <= starve_d;
            if_gnt_q    <= if_gnt_d;
            d_gnt_q     <= d_gnt_d;
            if_valid_q  <= if_valid_d;
            d_valid_q   <= d_valid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign if_gnt    = if_gnt_q;
    assign d_gnt     = d_gnt_q;
    assign if_valid  = if_valid_q;
    assign d_valid   = d_valid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign stall_if  = if_req && !if_valid_q;
    assign stall_d   = d_req && !d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table of single accesses plus
// hand-written sequences for arbitration, starvation, reset and latency builds.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int LMain = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we;
    MemAddr      if_addr, d_addr;
    logic [31:0] d_wdata;
    logic        if_gnt, if_valid, d_gnt, d_valid;
    logic [31:0] if_rdata, d_rdata;
    logic        mem_en, mem_we;
    MemAddr      mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        stall_if, stall_d;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LATENCY(LMain), .STARVE_LIMIT(3)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_d(stall_d)
    );

    // Memory contents as a pure function of the address.
    function automatic logic [31:0] rd_val(input MemAddr a);
        return (a == 16'h0003) ? 32'hDEAD_BEEF : {16'hA5A5, a};
    endfunction

    // Fixed-latency memory: data appears L cycles after the mem_en cycle, poison otherwise.
    logic [31:0] pd [4];
    logic        pv [4] = '{default: 1'b0};
    always @(posedge clk) begin
        pv[0] <= mem_en && !mem_we;
        pd[0] <= rd_val(mem_addr);
        for (int i = 1; i < 4; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
        end
    end
    assign mem_rdata = pv[LMain-1] ? pd[LMain-1] : 32'hBADB_AD00;

    // Extra builds with latency 1 and 4, fetch-only at address 7.
    localparam int XLat [2] = '{1, 4};
    logic [1:0]       x_if_req = 2'b00;
    logic [1:0]       x_if_valid;
    logic [1:0][31:0] x_if_rdata;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lat
            logic [31:0] xpd [4];
            logic        xpv [4] = '{default: 1'b0};
            logic [31:0] x_rdata, x_d_rdata, x_mem_wdata;
            logic        x_if_gnt, x_d_gnt, x_d_valid, x_mem_en, x_mem_we, x_stall_if, x_stall_d;
            MemAddr      x_mem_addr;

            always @(posedge clk) begin
                xpv[0] <= x_mem_en && !x_mem_we;
                xpd[0] <= rd_val(x_mem_addr);
                for (int i = 1; i < 4; i++) begin
                    xpv[i] <= xpv[i-1];
                    xpd[i] <= xpd[i-1];
                end
            end
            assign x_rdata = xpv[XLat[gi]-1] ? xpd[XLat[gi]-1] : 32'hBADB_AD00;

            mem_port_arbiter #(.MEM_LATENCY(XLat[gi]), .STARVE_LIMIT(3)) u_dut (
                .clk(clk), .rst(rst),
                .if_req(x_if_req[gi]), .if_addr(16'h0007), .if_gnt(x_if_gnt),
                .if_valid(x_if_valid[gi]), .if_rdata(x_if_rdata[gi]),
                .d_req(1'b0), .d_we(1'b0), .d_addr(16'h0000), .d_wdata(32'h0),
                .d_gnt(x_d_gnt), .d_valid(x_d_valid), .d_rdata(x_d_rdata),
                .mem_en(x_mem_en), .mem_we(x_mem_we), .mem_addr(x_mem_addr), .mem_wdata(x_mem_wdata),
                .mem_rdata(x_rdata), .stall_if(x_stall_if), .stall_d(x_stall_d)
            );
        end
    endgenerate

    typedef struct {
        string       name;
        logic        if_req;
        MemAddr      if_addr;
        logic        d_req;
        logic        d_we;
        MemAddr      d_addr;
        logic [31:0] d_wdata;
        logic        exp_if_gnt;
        logic        exp_d_gnt;
        logic        exp_we;
        MemAddr      exp_addr;
        logic [31:0] exp_wdata;
        int          exp_wait;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_reqs();
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
    endtask

    // One access from IDLE: check grant cycle, wait for valid, check data and stalls.
    task automatic apply_vec(input vec_t v);
        int   n;
        logic stall_ok;
        if_req = v.if_req; if_addr = v.if_addr;
        d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
        #1;
        check({v.name, " stall@t"}, {30'd0, stall_if, stall_d}, {30'd0, v.if_req, v.d_req});
        tick();
        check({v.name, " gnt/en"}, {29'd0, if_gnt, d_gnt, mem_en}, {29'd0, v.exp_if_gnt, v.exp_d_gnt, 1'b1});
        check({v.name, " mem_we"}, {31'd0, mem_we}, {31'd0, v.exp_we});
        check({v.name, " mem_addr"}, {16'd0, mem_addr}, {16'd0, v.exp_addr});
        check({v.name, " mem_wdata"}, mem_wdata, v.exp_wdata);
        n = 0;
        stall_ok = 1'b1;
        while (!(if_valid || d_valid) && n < 20) begin
            if ({stall_if, stall_d} != {v.if_req, v.d_req}) stall_ok = 1'b0;
            tick();
            n++;
        end
        check({v.name, " valid latency"}, 32'(n), 32'(v.exp_wait));
        check({v.name, " stall held"}, {31'd0, stall_ok}, 32'd1);
        check({v.name, " valid owner"}, {30'd0, if_valid, d_valid}, {30'd0, v.exp_if_gnt, v.exp_d_gnt});
        check({v.name, " rdata"}, v.exp_if_gnt ? if_rdata : d_rdata, v.exp_rdata);
        check({v.name, " stall@valid"}, {30'd0, stall_if, stall_d}, 32'd0);
        $display("[TB] %s: latency %0d, rdata %h", v.name, n, v.exp_if_gnt ? if_rdata : d_rdata);
        drop_reqs();
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   g;
        logic seen;
        logic [7:0] order;
        logic [7:0] exp_order;

        vecs[0] = '{"fetch rd 3",  1'b1, 16'h0003, 1'b0, 1'b0, 16'h00EE, 32'hCAFE_0001,
                    1'b1, 1'b0, 1'b0, 16'h0003, 32'h0, 3, 32'hDEAD_BEEF};
        vecs[1] = '{"data wr A",   1'b0, 16'h0000, 1'b1, 1'b1, 16'h000A, 32'h1234_5678,
                    1'b0, 1'b1, 1'b1, 16'h000A, 32'h1234_5678, 1, 32'h0};
        vecs[2] = '{"data rd 5",   1'b0, 16'h0000, 1'b1, 1'b0, 16'h0005, 32'h0,
                    1'b0, 1'b1, 1'b0, 16'h0005, 32'h0, 3, 32'hA5A5_0005};
        vecs[3] = '{"fetch rd FFFF", 1'b1, 16'hFFFF, 1'b0, 1'b1, 16'h0011, 32'hFFFF_0000,
                    1'b1, 1'b0, 1'b0, 16'hFFFF, 32'h0, 3, 32'hA5A5_FFFF};
        vecs[4] = '{"data wr 0",   1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 32'hFFFF_FFFF,
                    1'b0, 1'b1, 1'b1, 16'h0000, 32'hFFFF_FFFF, 1, 32'h0};
        vecs[5] = '{"data rd 3",   1'b0, 16'h0000, 1'b1, 1'b0, 16'h0003, 32'h0,
                    1'b0, 1'b1, 1'b0, 16'h0003, 32'h0, 3, 32'hDEAD_BEEF};

        // Reset state
        rst = 1'b1;
        drop_reqs();
        tick(); tick();
        check("reset ctrl", {25'd0, if_gnt, d_gnt, if_valid, d_valid, mem_en, mem_we, stall_if},
              32'd0);
        check("reset if_rdata", if_rdata, 32'd0);
        check("reset d_rdata", d_rdata, 32'd0);
        check("reset mem bus", {16'd0, mem_addr} | mem_wdata, 32'd0);
        rst = 1'b0;
        tick();
        check("idle no req", {28'd0, if_gnt, d_gnt, mem_en, stall_d}, 32'd0);

        // Latency builds L=1 and L=4
        for (int k = 0; k < 2; k++) begin
            x_if_req[k] = 1'b1;
            n = 0;
            while (!x_if_valid[k] && n < 20) begin
                tick();
                n++;
            end
            check($sformatf("L=%0d valid cycle", XLat[k]), 32'(n), 32'(XLat[k] + 2));
            check($sformatf("L=%0d rdata", XLat[k]), x_if_rdata[k], 32'hA5A5_0007);
            $display("[TB] L=%0d fetch: valid at t+%0d, rdata %h", XLat[k], n, x_if_rdata[k]);
            x_if_req[k] = 1'b0;
            tick();
        end

        // Single-access vector table
        for (int i = 0; i < 6; i++) begin
            apply_vec(vecs[i]);
        end

        // Simultaneous arrival: data first, fetch held and granted in the next IDLE
        if_req = 1'b1; if_addr = 16'h0007;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0002; d_wdata = 32'h0000_0055;
        tick();
        check("simul t+1 gnt", {30'd0, if_gnt, d_gnt}, 32'd1);
        tick();
        check("simul t+2 d_valid", {30'd0, if_valid, d_valid}, 32'd1);
        d_req = 1'b0; d_we = 1'b0;
        tick();
        check("simul t+3 wait", {30'd0, if_gnt, stall_if}, 32'd1);
        tick();
        check("simul t+4 if_gnt", {31'd0, if_gnt}, 32'd1);
        check("simul t+4 addr", {16'd0, mem_addr}, 32'h0000_0007);
        n = 0;
        while (!if_valid && n < 20) begin tick(); n++; end
        check("simul if latency", 32'(n), 32'd3);
        check("simul if_rdata", if_rdata, 32'hA5A5_0007);
        $display("[TB] simultaneous arrival: fetch served, rdata %h", if_rdata);
        drop_reqs();
        tick();

        // Reset during WAIT of a data read
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0009;
        tick();
        check("rstmid grant", {31'd0, d_gnt}, 32'd1);
        tick();
        rst = 1'b1;
        drop_reqs();
        #1;
        check("rstmid ctrl", {26'd0, if_gnt, d_gnt, if_valid, d_valid, mem_en, mem_we}, 32'd0);
        check("rstmid rdata", if_rdata | d_rdata, 32'd0);
        tick(); tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (if_valid || d_valid || mem_en) seen = 1'b1;
            tick();
        end
        check("rstmid no valid", {31'd0, seen}, 32'd0);
        check("rstmid late rdata", d_rdata, 32'd0);
        $display("[TB] reset mid-access: abandoned, late data ignored");
        apply_vec('{"post-rst rd 9", 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0009, 32'h0,
                    1'b0, 1'b1, 1'b0, 16'h0009, 32'h0, 3, 32'hA5A5_0009});

        // Both requesting continuously: D D D IF D D D IF
        if_req = 1'b1; if_addr = 16'h0001;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0004; d_wdata = 32'h0;
        exp_order = 8'b1000_1000;
        order = 8'h00;
        g = 0;
        n = 0;
        while (g < 8 && n < 200) begin
            tick();
            n++;
            if (if_gnt || d_gnt) begin
                order[g] = if_gnt;
                $display("[TB] starve grant %0d: %s", g, if_gnt ? "IF" : "D");
                g++;
            end
        end
        check("starve grant count", 32'(g), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("starve grant %0d is IF", i), {31'd0, order[i]}, {31'd0, exp_order[i]});
        end
        drop_reqs();
        for (int c = 0; c < 8; c++) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
